// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver (start, 8 data LSB first, optional parity, stop).
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around the bit centre;
// when undefined a single centre sample is used with identical timing.
// OVERSAMPLE: even, >= 6. The frame verdict is registered one tick before the last stop tick,
// so every output is driven from a flop.
module uart_rx_core #(
   parameter int unsigned OVERSAMPLE = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   output logic [7:0] P_DATA,
   output logic       DATA_VALID,
   output logic       PAR_ERR,
   output logic       STP_ERR
);

   localparam int unsigned EW = $clog2(OVERSAMPLE);
   localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
   localparam logic [EW-1:0] EDGE_PRE  = EW'(OVERSAMPLE - 2);
   localparam logic [EW-1:0] EDGE_MID  = EW'(OVERSAMPLE / 2);
   localparam logic [EW-1:0] EDGE_RES  = EW'(OVERSAMPLE / 2 + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state, state_nx;
   logic [EW-1:0] edge_cnt, edge_cnt_nx;
   logic [2:0]    bit_cnt, bit_cnt_nx;
   logic [7:0]    shift_q, shift_nx;
   logic          pen_q, pen_nx;
   logic          ptyp_q, ptyp_nx;
   logic          par_bad_q, par_bad_nx;
   logic          stop_q, stop_nx;
   logic          s_mid_q;
   logic          bit_val;
   logic          stop_now;
   logic [7:0]    p_data_nx;
   logic          dv_nx, pe_nx, se_nx;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [EW-1:0] EDGE_EARLY = EW'(OVERSAMPLE / 2 - 1);
   logic s_early_q;

   // Capture the two early votes; the third vote is the live line at the resolve tick.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s_early_q <= 1'b1;
         s_mid_q   <= 1'b1;
      end else begin
         if (edge_cnt == EDGE_EARLY) s_early_q <= RX_IN;
         if (edge_cnt == EDGE_MID)   s_mid_q   <= RX_IN;
      end
   end

   // 2-of-3 majority, valid at the resolve tick.
   always_comb begin
      bit_val = (s_early_q & s_mid_q) | (s_early_q & RX_IN) | (s_mid_q & RX_IN);
   end
`else
   // Single centre sample, held one tick so the resolve tick matches the majority build.
   always_ff @(posedge CLK) begin
      if (RST)                        s_mid_q <= 1'b1;
      else if (edge_cnt == EDGE_MID)  s_mid_q <= RX_IN;
   end

   // Resolved bit is the held centre sample.
   always_comb begin
      bit_val = s_mid_q;
   end
`endif

   // Frame state, counters, shift register and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         shift_q    <= '0;
         pen_q      <= 1'b0;
         ptyp_q     <= 1'b0;
         par_bad_q  <= 1'b0;
         stop_q     <= 1'b1;
         P_DATA     <= 8'h00;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
      end else begin
         state      <= state_nx;
         edge_cnt   <= edge_cnt_nx;
         bit_cnt    <= bit_cnt_nx;
         shift_q    <= shift_nx;
         pen_q      <= pen_nx;
         ptyp_q     <= ptyp_nx;
         par_bad_q  <= par_bad_nx;
         stop_q     <= stop_nx;
         P_DATA     <= p_data_nx;
         DATA_VALID <= dv_nx;
         PAR_ERR    <= pe_nx;
         STP_ERR    <= se_nx;
      end
   end

   // Next-state, datapath updates and the end-of-frame verdict.
   always_comb begin
      state_nx    = state;
      edge_cnt_nx = (edge_cnt == EDGE_LAST) ? '0 : edge_cnt + EW'(1);
      bit_cnt_nx  = bit_cnt;
      shift_nx    = shift_q;
      pen_nx      = pen_q;
      ptyp_nx     = ptyp_q;
      par_bad_nx  = par_bad_q;
      stop_nx     = stop_q;
      p_data_nx   = P_DATA;
      dv_nx       = 1'b0;
      pe_nx       = 1'b0;
      se_nx       = 1'b0;
      // Stop value bypass covers OVERSAMPLE=6, where resolve and verdict ticks coincide.
      stop_now    = (edge_cnt == EDGE_RES) ? bit_val : stop_q;

      case (state)
         IDLE: begin
            edge_cnt_nx = '0;
            bit_cnt_nx  = '0;
            if (!RX_IN) begin
               state_nx    = START;
               edge_cnt_nx = EW'(1);
               pen_nx      = PAR_EN;
               ptyp_nx     = PAR_TYP;
               par_bad_nx  = 1'b0;
            end
         end
         START: begin
            if ((edge_cnt == EDGE_RES) && bit_val) begin
               state_nx    = IDLE;
               edge_cnt_nx = '0;
            end else if (edge_cnt == EDGE_LAST) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            if (edge_cnt == EDGE_RES) shift_nx = {bit_val, shift_q[7:1]};
            if (edge_cnt == EDGE_LAST) begin
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nx = pen_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (edge_cnt == EDGE_RES) par_bad_nx = bit_val != ((^shift_q) ^ ptyp_q);
            if (edge_cnt == EDGE_LAST) state_nx = STOP;
         end
         STOP: begin
            if (edge_cnt == EDGE_RES) stop_nx = bit_val;
            if (edge_cnt == EDGE_PRE) begin
               se_nx = !stop_now;
               pe_nx = par_bad_q;
               if (stop_now && !par_bad_q) begin
                  dv_nx     = 1'b1;
                  p_data_nx = shift_q;
               end
            end
            if (edge_cnt == EDGE_LAST) state_nx = IDLE;
         end
         default: begin
            state_nx    = IDLE;
            edge_cnt_nx = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core with directed and random frames.
module tb_uart_rx_core;

   localparam int unsigned OS = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       pen;
   logic       ptyp;
   logic [7:0] p_data;
   logic       dv;
   logic       perr;
   logic       serr;

   typedef struct {
      logic        v;
      logic        pe;
      logic        se;
      logic [7:0]  d;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned n_checks  = 0;
   int unsigned n_errors  = 0;
   int unsigned cyc       = 0;
   logic [7:0]  last_good = 8'h00;
   logic [7:0]  exp_pdata = 8'h00;

   uart_rx_core #(.OVERSAMPLE(OS)) dut (
      .CLK       (clk),
      .RST       (rst),
      .RX_IN     (rx),
      .PAR_EN    (pen),
      .PAR_TYP   (ptyp),
      .P_DATA    (p_data),
      .DATA_VALID(dv),
      .PAR_ERR   (perr),
      .STP_ERR   (serr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop the scoreboard on every pulse; otherwise P_DATA must hold.
   always @(negedge clk) begin
      if (rst) begin
         exp_pdata = 8'h00;
      end else if (dv || perr || serr) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pulse: dv=%0b perr=%0b serr=%0b at cycle %0d", dv, perr, serr, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("data_valid", 32'(dv),     32'(mon_e.v));
            check("par_err",    32'(perr),   32'(mon_e.pe));
            check("stp_err",    32'(serr),   32'(mon_e.se));
            check("p_data",     32'(p_data), 32'(mon_e.d));
            check("pulse_cycle", cyc, mon_e.cyc);
            exp_pdata = mon_e.d;
         end
      end else begin
         check("p_data_hold", 32'(p_data), 32'(exp_pdata));
      end
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (OS) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference: pulse at start + N*OS - 1 with N = 10 or 11; parity = XOR of data, inverted if odd.
   task automatic send_frame(input logic [7:0] d, input logic pe_en, input logic pt,
                             input logic pbit, input logic stop, input bit scramble);
      exp_t        e;
      int unsigned s;
      logic        bad_par;
      s       = cyc;
      pen     = pe_en;
      ptyp    = pt;
      bad_par = pe_en && (pbit != ((^d) ^ pt));
      e.pe    = bad_par;
      e.se    = !stop;
      e.v     = !bad_par && stop;
      if (e.v) last_good = d;
      e.d     = last_good;
      e.cyc   = s + (pe_en ? 11 : 10) * OS - 1;
      sb.push_back(e);
      drive_bit(1'b0);
      if (scramble) begin
         pen  = 1'($urandom);
         ptyp = 1'($urandom);
      end
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pe_en) drive_bit(pbit);
      drive_bit(stop);
   endtask

   task automatic glitch(input int unsigned len);
      rx = 1'b0;
      repeat (len) @(posedge clk);
      #1;
      idle(2 * OS);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d pulses still pending at cycle %0d", sb.size(), cyc);
         sb.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_p_data"},     32'(p_data), 32'h00);
      check({tag, "_data_valid"}, 32'(dv),     32'h0);
      check({tag, "_par_err"},    32'(perr),   32'h0);
      check({tag, "_stp_err"},    32'(serr),   32'h0);
   endtask

   initial begin
      #(20000 * 10);
      $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       pe_en, pt, pbit, stop;
      rst  = 1'b1;
      rx   = 1'b1;
      pen  = 1'b0;
      ptyp = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("reset");
      idle(4);

      // Directed frames from the plan.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2);
      send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(2);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(5);

      // Short low pulses must be rejected as start glitches.
      for (int len = 1; len <= int'(OS / 2); len++) glitch(len);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);

      // Back-to-back, then reset 40 cycles into a third frame.
      send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      drain();
      rx  = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      last_good = 8'h00;
      check_reset_outputs("midreset");
      idle(3);
      send_frame(8'h6E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Break: line held low through consecutive frames.
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2);

      // Random frames with mid-frame PAR_EN/PAR_TYP scrambling.
      for (int n = 0; n < 40; n++) begin
         d     = 8'($urandom);
         pe_en = 1'($urandom);
         pt    = 1'($urandom);
         pbit  = (^d) ^ pt ^ ($urandom_range(0, 4) == 0);
         stop  = ($urandom_range(0, 6) != 0);
         send_frame(d, pe_en, pt, pbit, stop, 1'b1);
         if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, OS / 2));
         idle($urandom_range(0, 3));
      end

      idle(4);
      drain();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
